// File: rtl/cic_pkg.sv
// Shared definitions for the CIC interpolator/decimator gain banks:
// filter order, bit-growth limits, rate range and the shift lookup.
package cic_pkg;

   localparam int CIC_N                = 4;
   localparam int MAX_BIT_GAIN_DEFAULT = 21;

   // Rate range accepted by both gain banks.
   localparam int RATE_W   = 8;
   localparam int RATE_MIN = 1;
   localparam int RATE_MAX = 128;

   // Width of a shift amount; holds 0..MAX_BIT_GAIN_DEFAULT.
   localparam int SHIFT_W  = 5;

   // Bit growth of the 4-stage, M=1 CIC: ceil(3*log2(rate)), i.e. the
   // smallest g with 2^g >= rate^3. Rates 0/1 give no growth and anything
   // above RATE_MAX is clamped to the growth at RATE_MAX.
   function automatic logic [SHIFT_W-1:0] bit_gain_int(input logic [RATE_W-1:0] rate);
      logic [23:0]        r3;
      logic [SHIFT_W-1:0] g;
      g  = '0;
      r3 = 24'(rate) * 24'(rate) * 24'(rate);
      if (rate > RATE_W'(RATE_MAX)) begin
         g = SHIFT_W'(MAX_BIT_GAIN_DEFAULT);
      end else if (rate > RATE_W'(RATE_MIN)) begin
         // Walk downwards so the last hit is the smallest sufficient shift.
         for (int k = MAX_BIT_GAIN_DEFAULT; k >= 0; k--) begin
            if ((24'd1 << k) >= r3) g = SHIFT_W'(k);
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/cic_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of a
// wide signed CIC word down to OUT_W bits. Shared by both gain banks.
module cic_round_sat #(
   parameter int IN_W  = 37,
   parameter int OUT_W = 16,
   parameter int SH_W  = 5
) (
   input  logic signed [IN_W-1:0]  i_data,
   input  logic        [SH_W-1:0]  i_shift,
   output logic signed [OUT_W-1:0] o_data
);

   // One guard bit above the input so adding the rounding constant never wraps.
   localparam logic signed [IN_W:0] ONE   = {{IN_W{1'b0}}, 1'b1};
   localparam logic signed [IN_W:0] W_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W:0] W_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [IN_W:0] w_ext;
   logic signed [IN_W:0] w_rnd;
   logic signed [IN_W:0] w_sum;
   logic signed [IN_W:0] w_shifted;

   // Add half an output LSB, shift arithmetically, then clamp to OUT_W.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned, which would infer a latch.
      w_rnd  = '0;
      o_data = '0;
      w_ext  = {i_data[IN_W-1], i_data};
      if (i_shift != '0) begin
         w_rnd = ONE << (i_shift - SH_W'(1));
      end
      w_sum     = w_ext + w_rnd;
      w_shifted = w_sum >>> i_shift;
      if (w_shifted > W_MAX) begin
         o_data = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (w_shifted < W_MIN) begin
         o_data = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         o_data = w_shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/cic_gain_bank_int.sv
// Output gain normalisation for the CIC interpolator: removes the
// rate-dependent bit growth with a rounded arithmetic shift, saturates to
// WIDTH bits and blanks the output while the CIC settles after reset or a
// rate change. Two register stages: the sample is captured together with
// the shift in force when it was accepted, then rounded/saturated into
// data_out.
module cic_gain_bank_int
   import cic_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int MAX_BIT_GAIN   = MAX_BIT_GAIN_DEFAULT,
   parameter int SETTLE_SAMPLES = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic        [RATE_W-1:0]        rate,
   input  logic                            in_valid,
   input  logic signed [WIDTH+MAX_BIT_GAIN-1:0] data_in,
   output logic                            out_valid,
   output logic signed [WIDTH-1:0]         data_out,
   output logic                            settling
);

   localparam int         IN_W        = WIDTH + MAX_BIT_GAIN;
   localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_SAMPLES);

   logic [RATE_W-1:0]      r_rate_q;
   logic [SHIFT_W-1:0]     r_shift_q;
   logic [7:0]             r_settle_cnt;

   logic                   r_s1_load;
   logic                   r_s1_valid;
   logic signed [IN_W-1:0] r_s1_data;
   logic [SHIFT_W-1:0]     r_s1_shift;

   logic                   w_rate_change;
   logic                   w_blank;
   logic signed [WIDTH-1:0] w_norm;

   assign w_rate_change = (rate != r_rate_q);
   assign w_blank       = (r_settle_cnt != 8'd0);
   assign settling      = w_blank;

   // Track the rate, reload the shift and restart blanking on any change.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (!rst_n) begin
         r_rate_q     <= RATE_W'(1);
         r_shift_q    <= '0;
         r_settle_cnt <= SETTLE_INIT;
      end else if (w_rate_change) begin
         r_rate_q     <= rate;
         r_shift_q    <= bit_gain_int(rate);
         r_settle_cnt <= SETTLE_INIT;
      end else if (in_valid && w_blank) begin
         r_settle_cnt <= r_settle_cnt - 8'd1;
      end
   end

   // Stage 1: capture the sample with the shift in force when it arrived.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_load  <= 1'b0;
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_shift <= '0;
      end else begin
         r_s1_load  <= in_valid;
         r_s1_valid <= in_valid && !w_blank;
         if (in_valid) begin
            r_s1_data  <= data_in;
            r_s1_shift <= r_shift_q;
         end
      end
   end

   cic_round_sat #(
      .IN_W  (IN_W),
      .OUT_W (WIDTH),
      .SH_W  (SHIFT_W)
   ) u_round_sat (
      .i_data  (r_s1_data),
      .i_shift (r_s1_shift),
      .o_data  (w_norm)
   );

   // Stage 2: register the normalised sample; blanked samples still update data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         data_out  <= '0;
      end else begin
         out_valid <= r_s1_valid;
         if (r_s1_load) begin
            data_out <= w_norm;
         end
      end
   end

endmodule

// File: tb/tb_cic_gain_bank_int.sv
// Directed bench for cic_gain_bank_int: settling, rounding, shift table,
// saturation, mid-stream rate change and asynchronous reset.
module tb_cic_gain_bank_int;

   localparam int WIDTH = 16;
   localparam int MBG   = 21;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic [7:0]                  rate;
   logic                        in_valid;
   logic signed [WIDTH+MBG-1:0] data_in;
   logic                        out_valid;
   logic signed [WIDTH-1:0]     data_out;
   logic                        settling;

   int    n_tests = 0;
   int    n_fail  = 0;
   string tname;

   // Stimulus/expectation table for one stream, indexed by sample number.
   int         sd [32];
   logic [7:0] sr [32];
   bit         ev [32];
   int         ed [32];
   bit         es [32];

   cic_gain_bank_int #(
      .WIDTH          (WIDTH),
      .MAX_BIT_GAIN   (MBG),
      .SETTLE_SAMPLES (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rate      (rate),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .out_valid (out_valid),
      .data_out  (data_out),
      .settling  (settling)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic set(input int k, input logic [7:0] r, input int d,
                      input bit v, input int e, input bit s);
      sr[k] = r; sd[k] = d; ev[k] = v; ed[k] = e; es[k] = s;
   endtask

   // Rate change at sample p (zero data, valid with old shift), then eight
   // blanked zero samples.
   task automatic load_block(input int p, input logic [7:0] r);
      set(p, r, 0, 1'b1, 0, 1'b0);
      for (int j = 1; j <= 8; j++) set(p + j, r, 0, 1'b0, 0, 1'b1);
   endtask

   // Drive n back-to-back samples; sample k's output is visible two
   // negedges after it is driven.
   task automatic stream(input int n);
      for (int k = 0; k < n + 2; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            check($sformatf("%s[%0d].valid", tname, k - 2), 32'(out_valid), 32'(ev[k-2]));
            check($sformatf("%s[%0d].data", tname, k - 2), 32'(data_out), ed[k-2]);
         end
         if (k < n) begin
            check($sformatf("%s[%0d].settling", tname, k), 32'(settling), 32'(es[k]));
            in_valid = 1'b1;
            data_in  = 37'(sd[k]);
            rate     = sr[k];
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   logic [7:0] walk_rate [10];
   int         walk_exp  [10];

   initial begin
      walk_rate = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd8, 8'd10, 8'd100, 8'd128, 8'd200};
      walk_exp  = '{32767, 32767, 32767, 32767, 16384, 4096, 2048, 2, 1, 1};

      rst_n    = 1'b0;
      rate     = 8'd1;
      in_valid = 1'b0;
      data_in  = '0;
      #12;
      check("reset.out_valid", 32'(out_valid), 0);
      check("reset.data_out", 32'(data_out), 0);
      check("reset.settling", 32'(settling), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Ten samples of 5 at rate 1: first eight blanked.
      tname = "settle";
      for (int k = 0; k < 10; k++) set(k, 8'd1, 5, k >= 8, 5, k < 8);
      stream(10);

      // Round half-up at shift 3.
      tname = "round";
      load_block(0, 8'd2);
      set(9,  8'd2,  12, 1'b1,  2, 1'b0);
      set(10, 8'd2,  11, 1'b1,  1, 1'b0);
      set(11, 8'd2, -12, 1'b1, -1, 1'b0);
      set(12, 8'd2, -13, 1'b1, -2, 1'b0);
      stream(13);

      // Shift table walk with a full-scale 21-bit input.
      for (int i = 0; i < 10; i++) begin
         tname = $sformatf("walk_r%0d", walk_rate[i]);
         load_block(0, walk_rate[i]);
         set(9, walk_rate[i], 2097151, 1'b1, walk_exp[i], 1'b0);
         stream(10);
      end

      // Saturation at rate 1.
      tname = "sat";
      load_block(0, 8'd1);
      set(9,  8'd1,  40000, 1'b1,  32767, 1'b0);
      set(10, 8'd1, -40000, 1'b1, -32768, 1'b0);
      set(11, 8'd1,  32767, 1'b1,  32767, 1'b0);
      set(12, 8'd1, -32769, 1'b1, -32768, 1'b0);
      stream(13);

      // Settle at rate 4, then switch to 8 mid-stream at sample 2.
      tname = "to_r4";
      load_block(0, 8'd4);
      set(9, 8'd4, 1000, 1'b1, 16, 1'b0);
      stream(10);
      tname = "r4_to_r8";
      set(0, 8'd4, 1000, 1'b1, 16, 1'b0);
      set(1, 8'd4, 1000, 1'b1, 16, 1'b0);
      set(2, 8'd8, 1000, 1'b1, 16, 1'b0);
      for (int k = 3; k <= 10; k++) set(k, 8'd8, 1000, 1'b0, 2, 1'b1);
      set(11, 8'd8, 1000, 1'b1, 2, 1'b0);
      set(12, 8'd8, 1000, 1'b1, 2, 1'b0);
      stream(13);

      // Asynchronous reset with two samples in flight.
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = 37'(1000);
      @(negedge clk);
      data_in  = 37'(2000);
      @(posedge clk);
      #1;
      check("pre_reset.out_valid", 32'(out_valid), 1);
      check("pre_reset.data_out", 32'(data_out), 2);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("async_reset.out_valid", 32'(out_valid), 0);
      check("async_reset.data_out", 32'(data_out), 0);
      check("async_reset.settling", 32'(settling), 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("post_reset[%0d].out_valid", k), 32'(out_valid), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cic_gain_bank_int.md
Name: cic_gain_bank_int

Overview:
- Output gain-normalisation stage for the 4-stage, M=1 CIC interpolator on the FM transmit path. It sits between the last CIC comb/integrator stage and the DAC/upconverter.
- The CIC interpolator grows the signal by R^(N-1), which is ceil(3*log2(rate)) bits. This block removes that growth with a rate-dependent arithmetic right shift, rounds half-up, and saturates to WIDTH bits.
- It is pipelined with a valid strobe. After a rate change or reset it blanks output until the CIC has settled.

Parameters:
- WIDTH, 16, output sample width (signed two's complement).
- MAX_BIT_GAIN, 21, maximum CIC bit growth; 3*log2(128).
- SETTLE_SAMPLES, 8, number of accepted samples suppressed after reset or a rate change; range 0..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rate  in  8  interpolation ratio R; quasi-static.
- in_valid  in  1  data_in carries a sample this cycle.
- data_in  in  WIDTH+MAX_BIT_GAIN  signed CIC output.
- out_valid  out  1  data_out carries a sample this cycle.
- data_out  out  WIDTH  signed normalised sample.
- settling  out  1  high while output blanking is active.

Behaviour:
- Shift table, shift = bit_gain(rate):
  - rate 0 or 1 -> 0; 2 -> 3; 4 -> 6; 8 -> 9; 16 -> 12; 32 -> 15; 64 -> 18; 128 -> 21.
  - Every other rate -> ceil(3*log2(rate)), e.g. 3 -> 5, 5 -> 7, 10 -> 10, 100 -> 20.
  - rate > 128 -> 21.
- Reset (async assert, sync-safe release): rate_q=1, shift_q=0, settle_cnt=SETTLE_SAMPLES, pipeline valids=0, out_valid=0, data_out=0, settling=(SETTLE_SAMPLES!=0).
- Rate tracking:
  - Each cycle, if rate != rate_q: at the next edge rate_q<=rate, shift_q<=bit_gain(rate), settle_cnt<=SETTLE_SAMPLES.
  - A sample accepted in that same cycle uses the old shift_q.
- Stage 1, on in_valid: s1 = (data_in + (shift_q>0 ? 2^(shift_q-1) : 0)) >>> shift_q.
  - Computed in WIDTH+MAX_BIT_GAIN+1 bits so no overflow.
  - The shift is registered with the sample.
- Stage 2: saturate s1 to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Register into data_out.
- Latency: out_valid asserts exactly 2 cycles after the accepting in_valid. Back-to-back in_valid gives back-to-back out_valid; throughput is 1 sample/cycle.
- Blanking:
  - While settle_cnt!=0, each accepted sample decrements settle_cnt and its out_valid is suppressed. The pipeline still advances and data_out still updates.
  - settling = (settle_cnt!=0).
  - A rate change during blanking reloads the counter.
  - SETTLE_SAMPLES=0 means no blanking ever.
- When in_valid is low, data_out holds its last value and out_valid=0.
- Reset mid-stream: in-flight samples are discarded; no out_valid for them.

Decomposition:
- Package cic_pkg holds:
  - the function bit_gain_int(rate) -> [4:0];
  - CIC_N=4 and MAX_BIT_GAIN_DEFAULT=21;
  - the shared rate-range constants used by the decimator gain bank.
- Sub-module cic_round_sat(IN_W, OUT_W, SH_W): combinational round-half-up, arithmetic shift and saturate. It is reusable by the decimator side.
- The top holds the rate register, settle counter and pipeline registers.

Test Plan:
- Reset, SETTLE_SAMPLES=8, rate=1, 10 consecutive valid samples of value 5 -> out_valid low for the first 8; samples 9 and 10 give data_out=5 at 2-cycle latency; settling drops after the 8th accept.
- Rounding, rate=2 (shift 3) after settling:
  - in=12 -> out=2.
  - in=11 -> out=1.
  - in=-12 -> out=-1.
  - in=-13 -> out=-2.
- Table walk: for rate in {1,2,3,4,5,8,10,100,128,200}, in=2^21-1 -> out = round((2^21-1)/2^shift), saturated. Expect rate 1 -> 32767, rate 128 -> 1, rate 200 -> 1.
- Saturation, rate=1: in=40000 -> 32767; in=-40000 -> -32768; in=32767 -> 32767.
- Rate change mid-stream: stream valid every cycle; switch rate 4 -> 8 at cycle T.
  - The sample accepted at T is output with shift 6 and valid.
  - The next 8 samples have out_valid suppressed and settling=1.
  - Then outputs use shift 9.
- Async reset asserted with 2 samples in flight -> out_valid=0 and data_out=0 immediately. No stale valid after release.
